// File: rtl/branch_resolve_pkg.sv
// Shared opcode constants, FSM state type and captured-request struct for branch_resolve.
package branch_resolve_pkg;

  localparam logic [7:0] OpJo     = 8'h70;
  localparam logic [7:0] OpJno    = 8'h71;
  localparam logic [7:0] OpJb     = 8'h72;
  localparam logic [7:0] OpJnb    = 8'h73;
  localparam logic [7:0] OpJz     = 8'h74;
  localparam logic [7:0] OpJnz    = 8'h75;
  localparam logic [7:0] OpJbe    = 8'h76;
  localparam logic [7:0] OpJnbe   = 8'h77;
  localparam logic [7:0] OpJs     = 8'h78;
  localparam logic [7:0] OpJns    = 8'h79;
  localparam logic [7:0] OpJp     = 8'h7A;
  localparam logic [7:0] OpJnp    = 8'h7B;
  localparam logic [7:0] OpJl     = 8'h7C;
  localparam logic [7:0] OpJnl    = 8'h7D;
  localparam logic [7:0] OpJle    = 8'h7E;
  localparam logic [7:0] OpJnle   = 8'h7F;
  localparam logic [7:0] OpLoopnz = 8'hE0;
  localparam logic [7:0] OpLoopz  = 8'hE1;
  localparam logic [7:0] OpLoop   = 8'hE2;
  localparam logic [7:0] OpJcxz   = 8'hE3;
  localparam logic [7:0] OpJmps   = 8'hEB;

  typedef enum logic [1:0] {StIdle, StEval, StCheck, StResp} state_e;

  typedef struct packed {
    logic        big;
    logic [7:0]  ir;
    logic        disp_long;
    logic [31:0] disp;
    logic [31:0] ecx;
    logic        zf;
    logic        cf;
    logic        sf;
    logic        vf;
    logic        pf;
  } branch_req_t;

endpackage

// File: rtl/evaluate_branch.sv
// Combinational taken/not-taken evaluator for relative control transfers.
module evaluate_branch
  import branch_resolve_pkg::*;
(
  input  logic [7:0]  ir_i,
  input  logic        big_i,
  input  logic [31:0] ecx_i,
  input  logic        zf_i,
  input  logic        cf_i,
  input  logic        sf_i,
  input  logic        vf_i,
  input  logic        pf_i,
  output logic        take_br_o
);

  logic [31:0] count;
  logic        cnt_ne1;
  logic        jcc;

  // Decode the condition; LOOP family tests the pre-decrement count.
  always_comb begin
    count   = big_i ? ecx_i : {16'h0, ecx_i[15:0]};
    cnt_ne1 = (count != 32'd1);
    // Jcc pairs share a base condition; bit 0 inverts it.
    case (ir_i[3:1])
      3'd0: jcc = vf_i;
      3'd1: jcc = cf_i;
      3'd2: jcc = zf_i;
      3'd3: jcc = cf_i | zf_i;
      3'd4: jcc = sf_i;
      3'd5: jcc = pf_i;
      3'd6: jcc = sf_i ^ vf_i;
      default: jcc = zf_i | (sf_i ^ vf_i);
    endcase
    take_br_o = 1'b0;
    if (ir_i[7:4] == 4'h7) begin
      take_br_o = jcc ^ ir_i[0];
    end else begin
      case (ir_i)
        OpJmps:   take_br_o = 1'b1;
        OpLoopnz: take_br_o = cnt_ne1 & ~zf_i;
        OpLoopz:  take_br_o = cnt_ne1 & zf_i;
        OpLoop:   take_br_o = cnt_ne1;
        OpJcxz:   take_br_o = (count == 32'd0);
        default:  take_br_o = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/branch_resolve.sv
// Execute-stage sequencer for relative jumps, Jcc, LOOPx and JCXZ with CS-limit check.
module branch_resolve
  import branch_resolve_pkg::*;
#(
  parameter int unsigned AW        = 32,
  parameter bit          CHK_LIMIT = 1'b1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          req_valid_i,
  output logic          req_ready_o,
  input  logic          big_i,
  input  logic [7:0]    ir_i,
  input  logic          disp_long_i,
  input  logic [31:0]   disp_i,
  input  logic [AW-1:0] next_eip_i,
  input  logic [31:0]   ecx_i,
  input  logic          zf_i,
  input  logic          cf_i,
  input  logic          sf_i,
  input  logic          vf_i,
  input  logic          pf_i,
  input  logic [AW-1:0] cs_limit_i,
  output logic          resp_valid_o,
  input  logic          resp_ready_i,
  output logic          redirect_o,
  output logic [AW-1:0] target_o,
  output logic          ecx_wr_o,
  output logic [31:0]   ecx_o,
  output logic          fault_gp_o,
  output logic          busy_o
);

  state_e      state_q, state_d;
  branch_req_t req_q, req_d;
  logic [AW-1:0] next_eip_q, next_eip_d, cs_limit_q, cs_limit_d;
  logic [AW-1:0] target_q, target_d;
  logic [31:0]   ecx_n_q, ecx_n_d;
  logic          take_q, take_d;
  // Registered response outputs.
  logic          resp_valid_q, resp_valid_d, redirect_q, redirect_d;
  logic          ecx_wr_q, ecx_wr_d, fault_q, fault_d;
  logic [AW-1:0] tgt_out_q, tgt_out_d;
  logic [31:0]   ecx_out_q, ecx_out_d;

  logic          take_br;
  logic [31:0]   sdisp;
  logic [AW-1:0] raw, tgt_calc;
  logic [31:0]   ecx_calc;
  logic          is_loop, fault;

  evaluate_branch u_eval (
    .ir_i      (req_q.ir),
    .big_i     (req_q.big),
    .ecx_i     (req_q.ecx),
    .zf_i      (req_q.zf),
    .cf_i      (req_q.cf),
    .sf_i      (req_q.sf),
    .vf_i      (req_q.vf),
    .pf_i      (req_q.pf),
    .take_br_o (take_br)
  );

  // Datapath: sign-extended displacement, wrapped target, decremented count, limit check.
  always_comb begin
    if (!req_q.disp_long)  sdisp = {{24{req_q.disp[7]}}, req_q.disp[7:0]};
    else if (!req_q.big)   sdisp = {{16{req_q.disp[15]}}, req_q.disp[15:0]};
    else                   sdisp = req_q.disp;
    raw      = next_eip_q + AW'($signed(sdisp));
    // 16-bit mode wraps IP at 64K.
    tgt_calc = req_q.big ? raw : AW'(raw[15:0]);
    ecx_calc = req_q.big ? (req_q.ecx - 32'd1) : {req_q.ecx[31:16], req_q.ecx[15:0] - 16'd1};
    is_loop  = req_q.ir inside {OpLoopnz, OpLoopz, OpLoop};
    fault    = CHK_LIMIT && take_q && (target_q > cs_limit_q);
  end

  // Next-state logic for the fixed IDLE->EVAL->CHECK->RESP sequence.
  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    next_eip_d   = next_eip_q;
    cs_limit_d   = cs_limit_q;
    target_d     = target_q;
    ecx_n_d      = ecx_n_q;
    take_d       = take_q;
    resp_valid_d = resp_valid_q;
    redirect_d   = redirect_q;
    ecx_wr_d     = ecx_wr_q;
    fault_d      = fault_q;
    tgt_out_d    = tgt_out_q;
    ecx_out_d    = ecx_out_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          req_d      = '{big: big_i, ir: ir_i, disp_long: disp_long_i, disp: disp_i,
                         ecx: ecx_i, zf: zf_i, cf: cf_i, sf: sf_i, vf: vf_i, pf: pf_i};
          next_eip_d = next_eip_i;
          cs_limit_d = cs_limit_i;
          state_d    = StEval;
        end
      end
      StEval: begin
        take_d   = take_br;
        target_d = tgt_calc;
        ecx_n_d  = ecx_calc;
        state_d  = StCheck;
      end
      StCheck: begin
        resp_valid_d = 1'b1;
        redirect_d   = take_q & ~fault;
        tgt_out_d    = (take_q & ~fault) ? target_q : next_eip_q;
        fault_d      = fault;
        // A faulting LOOP leaves ECX untouched so it can restart.
        ecx_wr_d     = is_loop & ~fault;
        ecx_out_d    = ecx_n_q;
        state_d      = StResp;
      end
      StResp: begin
        if (resp_ready_i) begin
          resp_valid_d = 1'b0;
          redirect_d   = 1'b0;
          tgt_out_d    = '0;
          fault_d      = 1'b0;
          ecx_wr_d     = 1'b0;
          ecx_out_d    = '0;
          state_d      = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers; reset abandons any operation in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      req_q        <= '0;
      next_eip_q   <= '0;
      cs_limit_q   <= '0;
      target_q     <= '0;
      ecx_n_q      <= '0;
      take_q       <= 1'b0;
      resp_valid_q <= 1'b0;
      redirect_q   <= 1'b0;
      ecx_wr_q     <= 1'b0;
      fault_q      <= 1'b0;
      tgt_out_q    <= '0;
      ecx_out_q    <= '0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      next_eip_q   <= next_eip_d;
      cs_limit_q   <= cs_limit_d;
      target_q     <= target_d;
      ecx_n_q      <= ecx_n_d;
      take_q       <= take_d;
      resp_valid_q <= resp_valid_d;
      redirect_q   <= redirect_d;
      ecx_wr_q     <= ecx_wr_d;
      fault_q      <= fault_d;
      tgt_out_q    <= tgt_out_d;
      ecx_out_q    <= ecx_out_d;
    end
  end

  assign req_ready_o  = (state_q == StIdle);
  assign busy_o       = (state_q != StIdle);
  assign resp_valid_o = resp_valid_q;
  assign redirect_o   = redirect_q;
  assign target_o     = tgt_out_q;
  assign ecx_wr_o     = ecx_wr_q;
  assign ecx_o        = ecx_out_q;
  assign fault_gp_o   = fault_q;

endmodule
